// File: rtl/add_serial_pkg.sv
// Shared types and defaults for the round-robin serial-add scheduler.
//   state_t    : scheduler FSM state (IDLE/ADD/DONE)
//   DEF_*      : default operand width and requester count
//   rr_index   : (base + off) mod n, used for the wrap-around arbiter search
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NREQ  = 4;

  // Wrap-around index; base and off are both below n, so one subtraction suffices.
  function automatic int unsigned rr_index(int unsigned base, int unsigned off, int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/add_serial_sched_if.sv
// Requester / response bundle for the serial-add scheduler.
//   req_valid/req_ready : per-requester handshake (req_ready at most one-hot)
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_sum/rsp_cout : tagged result
// master = requesters + consumer side, slave = scheduler side.
interface add_serial_sched_if
  import add_serial_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/add_serial_core.sv
// Bit-serial LSB-first adder datapath.
//   clk, rst    : clock, async active-low reset
//   load        : capture a_in/b_in, clear count and carry
//   shift       : process one bit (a/b shift right, sum bit into result MSB)
//   a_in, b_in  : operands captured on load
//   sum, cout   : registered result, updated only on the final bit
//   last_c      : combinational, high while the next shift is the final bit
module add_serial_core
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             last_c
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    count_q;
  logic             bit_c;
  logic             carry_c;

  // Full-adder slice on the current LSBs.
  assign bit_c   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_c  = (count_q == CW'(WIDTH - 1));

  // Operand/result shift registers; sum/cout hold the last completed result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      a_q     <= a_in;
      b_q     <= b_in;
      carry_q <= 1'b0;
      count_q <= '0;
    end else if (shift) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= {bit_c, res_q[WIDTH-1:1]};
      carry_q <= carry_c;
      count_q <= count_q + CW'(1);
      if (last_c) begin
        sum  <= {bit_c, res_q[WIDTH-1:1]};
        cout <= carry_c;
      end
    end
  end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of add_serial_sched_if (requests in, tagged result out)
//   busy     : registered, high whenever the FSM is not in IDLE
// req_ready is the only combinational output (from req_valid, ptr and state).
module add_serial_sched
  import add_serial_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  add_serial_sched_if.slave bus,
  output logic             busy
);
  localparam int unsigned IDW = $clog2(NREQ);

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   gnt_id_c;
  logic             gnt_found_c;
  logic [NREQ-1:0]  gnt_c;
  logic             load_c;
  logic             shift_c;
  logic             last_c;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // First valid requester at or after ptr, with wrap.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_id_c    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_found_c && bus.req_valid[rr_index(32'(ptr_q), k, NREQ)]) begin
        gnt_found_c = 1'b1;
        gnt_id_c    = IDW'(rr_index(32'(ptr_q), k, NREQ));
      end
    end
  end

  // Next-state and datapath controls.
  always_comb begin
    state_d = state_q;
    gnt_c   = '0;
    load_c  = 1'b0;
    shift_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found_c) begin
          gnt_c   = NREQ'(1) << gnt_id_c;
          load_c  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        shift_c = 1'b1;
        if (last_c) state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and result tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= (state_d == DONE);
      busy        <= (state_d != IDLE);
      if (load_c) id_q <= gnt_id_c;
      // Tag is published with the result so it survives the next accept.
      if (state_q == ADD && last_c) rsp_id_q <= id_q;
      if (state_q == DONE && bus.rsp_ready)
        ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
    end
  end

  add_serial_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .shift  (shift_c),
    .a_in   (bus.req_a[gnt_id_c*WIDTH +: WIDTH]),
    .b_in   (bus.req_b[gnt_id_c*WIDTH +: WIDTH]),
    .sum    (sum),
    .cout   (cout),
    .last_c (last_c)
  );

  assign bus.req_ready = gnt_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = sum;
  assign bus.rsp_cout  = cout;

endmodule
